// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory-bus arbiter: FSM state encoding,
// bus record widths and the error read-data pattern.
package mem_bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // request record is {valid, addr, wdata, wstrb}
  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // response record is {rdata, ready}
  function automatic int resp_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundled master-side and slave-side buses of the arbiter.
// Master 0 occupies the least-significant slice of each packed vector.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int REQ_W  = req_w(ADDR_W, DATA_W);
  localparam int RESP_W = resp_w(DATA_W);

  logic [N_MASTERS*REQ_W-1:0]  m_req;
  logic [N_MASTERS*RESP_W-1:0] m_resp;
  logic [REQ_W-1:0]            s_req;
  logic [RESP_W-1:0]           s_resp;

  // the arbiter: serves the masters and drives the shared slave
  modport slave  (input m_req, output m_resp, output s_req, input s_resp);
  // the surroundings: masters plus the shared slave
  modport master (output m_req, input m_resp, input s_req, output s_resp);
endinterface

// File: rtl/mem_bus_arbiter_arb_rr_sel.sv
// Combinational round-robin selector: first requester at or after i_ptr,
// searching upward with wrap. o_winner is 0 when nobody requests.
module arb_rr_sel #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_winner,
  output logic          o_any
);
  logic [IW:0] w_sum;
  logic [IW:0] w_idx;

  // scan from farthest to nearest so the nearest requester wins
  always_comb begin
    o_winner = '0;
    o_any    = |i_req;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum    = {1'b0, i_ptr} + (IW+1)'(k);
      w_idx    = (w_sum >= (IW+1)'(N)) ? w_sum - (IW+1)'(N) : w_sum;
      o_winner = i_req[w_idx[IW-1:0]] ? w_idx[IW-1:0] : o_winner;
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one native-bus slave between N_MASTERS masters.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN (adds o_timeout).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter  int N_MASTERS      = 2,
  parameter  int ADDR_W         = 32,
  parameter  int DATA_W         = 32,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int GID_W          = $clog2(N_MASTERS)
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus,
  output logic [GID_W-1:0] o_grant_id,
  output logic             o_busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             o_timeout
`endif
);
  localparam int REQ_W  = req_w(ADDR_W, DATA_W);
  localparam int RESP_W = resp_w(DATA_W);

  arb_state_e       r_state, w_state_nx;
  logic [GID_W-1:0] r_grant, w_grant_nx;
  logic [GID_W-1:0] r_ptr, w_ptr_nx;
  logic [GID_W-1:0] w_winner;
  logic             w_any;
  logic [N_MASTERS-1:0] w_valid;
  logic [REQ_W-1:0] w_sel_req;
  logic             w_sel_valid;
  logic             w_s_ready;
  logic             w_expire;

  // gather the valid bit (MSB) of every master's request
  always_comb begin
    w_valid = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_valid[i] = bus.m_req[i*REQ_W + REQ_W - 1];
    end
  end

  assign w_sel_req   = bus.m_req[r_grant*REQ_W +: REQ_W];
  assign w_sel_valid = w_sel_req[REQ_W-1];
  assign w_s_ready   = bus.s_resp[0];

  arb_rr_sel #(.N(N_MASTERS)) u_sel (
    .i_req    (w_valid),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  assign w_expire = (r_state == ST_BUSY) && w_sel_valid && !w_s_ready
                    && (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  // BUSY-cycle counter and sticky watchdog flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= (r_state == ST_BUSY) ? r_cnt + CNT_W'(1) : '0;
      r_timeout <= r_timeout | w_expire;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_expire = 1'b0;
`endif

  // state, grant and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_ptr   <= w_ptr_nx;
    end
  end

  // next state plus slave mux and response routing; a dropped valid aborts
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_ptr_nx   = r_ptr;
    bus.s_req  = '0;
    bus.m_resp = '0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            w_state_nx = ST_BUSY;
            w_grant_nx = w_winner;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
        ST_BUSY: begin
          bus.s_req = w_sel_req;
          if (w_sel_valid) begin
            bus.m_resp[r_grant*RESP_W +: RESP_W] =
                w_expire ? {DATA_W'(ERR_RDATA), 1'b1} : bus.s_resp;
          end else begin
            bus.m_resp = '0;
          end
          if (!w_sel_valid || w_s_ready || w_expire) begin
            w_state_nx = ST_IDLE;
            w_ptr_nx   = (r_grant == GID_W'(N_MASTERS - 1)) ? '0 : r_grant + GID_W'(1);
          end else begin
            w_state_nx = ST_BUSY;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end else begin
      w_state_nx = ST_IDLE;
    end
  end

  assign o_grant_id = r_grant;
  assign o_busy     = (r_state == ST_BUSY) && !rst;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter (N=4) and arb_rr_sel: selector vector table,
// directed corner sequences, then random traffic against a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int N      = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TO     = 8;
  localparam int REQ_W  = 1 + AW + DW + DW / 8;
  localparam int RESP_W = DW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [1:0] grant_id;
  logic       busy;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  mem_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_grant_id (grant_id),
    .o_busy     (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .o_timeout  (timeout)
`endif
  );

  logic [3:0] sel_req;
  logic [1:0] sel_ptr;
  logic [1:0] sel_win;
  logic       sel_any;

  arb_rr_sel #(.N(4)) u_sel (.i_req(sel_req), .i_ptr(sel_ptr), .o_winner(sel_win), .o_any(sel_any));

  typedef struct {
    logic [3:0] req;
    logic [1:0] ptr;
    logic [1:0] win;
    logic       any;
  } sel_vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // master and slave stimulus
  logic        mv[N];
  logic [31:0] ma[N];
  logic [31:0] mw[N];
  logic [3:0]  ms[N];
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [N-1:0] got;

  // reference model: granted master (-1 when idle), pointer, BUSY cycle count
  int gnt = -1;
  int ptr = 0;
  int gid = 0;
  int bcnt = 0;
  bit tmo = 1'b0;
  int done_q[$];

  logic [REQ_W-1:0]    smp_sreq;
  logic [N*RESP_W-1:0] smp_mresp;
  logic                smp_busy;
  logic [1:0]          smp_gid;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] sel_ref(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return {1'b1, 2'((p + k) % 4)};
    end
    return 3'b000;
  endfunction

  // one clock cycle: drive, compare against model, advance model, wait next negedge
  task automatic step();
    logic [N*REQ_W-1:0]  r;
    logic [REQ_W-1:0]    es;
    logic [N*RESP_W-1:0] er;
    logic [RESP_W-1:0]   rs;
    bit found;
    r = '0;
    for (int i = 0; i < N; i++) r[i*REQ_W +: REQ_W] = {mv[i], ma[i], mw[i], ms[i]};
    bus.m_req  = r;
    bus.s_resp = {s_rdata, s_ready};
    #1;
    es = '0;
    er = '0;
    if (!rst && gnt >= 0) begin
      es = r[gnt*REQ_W +: REQ_W];
      if (mv[gnt]) begin
        rs = {s_rdata, s_ready};
`ifdef ARB_TIMEOUT_EN
        if (!s_ready && bcnt == TO) rs = {32'hDEADBEEF, 1'b1};
`endif
        er[gnt*RESP_W +: RESP_W] = rs;
      end
    end
    smp_sreq  = bus.s_req;
    smp_mresp = bus.m_resp;
    smp_busy  = busy;
    smp_gid   = grant_id;
    check("s_req", 160'(smp_sreq), 160'(es));
    check("m_resp", 160'(smp_mresp), 160'(er));
    check("busy", 160'(smp_busy), 160'(!rst && gnt >= 0));
    check("grant_id", 160'(smp_gid), 160'(gid));
`ifdef ARB_TIMEOUT_EN
    check("timeout", 160'(timeout), 160'(tmo));
`endif
    for (int i = 0; i < N; i++) got[i] = er[i*RESP_W];
    if (rst) begin
      gnt = -1; ptr = 0; gid = 0; tmo = 1'b0;
    end else if (gnt < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && mv[(ptr + k) % N]) begin
          found = 1'b1; gnt = (ptr + k) % N; gid = gnt; bcnt = 0;
        end
      end
    end else if (!mv[gnt] || got[gnt]) begin
      if (got[gnt]) begin
        done_q.push_back(gnt);
        if (!s_ready) tmo = 1'b1;
      end
      ptr = (gnt + 1) % N;
      gnt = -1;
    end else begin
      bcnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic clear_masters();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; ma[i] = 32'(i) << 8; mw[i] = 32'h0; ms[i] = 4'h0;
    end
  endtask

  initial begin
    sel_vec_t tbl[8];
    int nb;
    int n0;
    tbl[0] = '{req: 4'b0110, ptr: 2'd3, win: 2'd1, any: 1'b1};
    tbl[1] = '{req: 4'b0000, ptr: 2'd2, win: 2'd0, any: 1'b0};
    tbl[2] = '{req: 4'b1000, ptr: 2'd0, win: 2'd3, any: 1'b1};
    tbl[3] = '{req: 4'b0001, ptr: 2'd1, win: 2'd0, any: 1'b1};
    tbl[4] = '{req: 4'b1111, ptr: 2'd2, win: 2'd2, any: 1'b1};
    tbl[5] = '{req: 4'b0101, ptr: 2'd2, win: 2'd2, any: 1'b1};
    tbl[6] = '{req: 4'b0011, ptr: 2'd2, win: 2'd0, any: 1'b1};
    tbl[7] = '{req: 4'b1010, ptr: 2'd2, win: 2'd3, any: 1'b1};
    for (int i = 0; i < 8; i++) begin
      sel_req = tbl[i].req; sel_ptr = tbl[i].ptr;
      #1;
      check("sel_tbl", 160'({sel_any, sel_win}), 160'({tbl[i].any, tbl[i].win}));
    end
    for (int p = 0; p < 4; p++) begin
      for (int q = 0; q < 16; q++) begin
        sel_req = 4'(q); sel_ptr = 2'(p);
        #1;
        check("sel_all", 160'({sel_any, sel_win}), 160'(sel_ref(4'(q), p)));
      end
    end

    // reset held with m0 requesting; the first edge is unchecked (registers unknown)
    clear_masters();
    s_ready = 1'b0; s_rdata = 32'h0;
    mv[0] = 1'b1; ma[0] = 32'h100;
    bus.m_req = '0; bus.s_resp = '0;
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_still_idle", 160'(smp_sreq[REQ_W-1]), 160'(0));
    step();
    check("rst_grant_valid", 160'(smp_sreq[REQ_W-1]), 160'(1));
    check("rst_grant_id", 160'(smp_gid), 160'(0));

    // single read, slave ready on the fourth valid cycle
    step(); step();
    s_ready = 1'b1; s_rdata = 32'h12345678;
    step();
    check("rd_m0_resp", 160'(smp_mresp[RESP_W-1:0]), 160'({32'h12345678, 1'b1}));
    check("rd_m1_ready", 160'(smp_mresp[RESP_W]), 160'(0));
    mv[0] = 1'b0; s_ready = 1'b0;
    step();
    check("rd_busy_fall", 160'(smp_busy), 160'(0));

    // contention between m0 and m1, slave always ready
    do_reset();
    mv[0] = 1'b1; mv[1] = 1'b1; s_ready = 1'b1; s_rdata = 32'hA5A5_0000;
    done_q.delete();
    for (int c = 0; c < 40 && done_q.size() < 6; c++) begin
      step();
      for (int i = 0; i < 2; i++) if (got[i]) mw[i] = mw[i] + 32'h1;
    end
    check("cont_count", 160'(done_q.size()), 160'(6));
    n0 = 0;
    for (int k = 0; k < done_q.size() && k < 6; k++) begin
      check("cont_order", 160'(done_q[k]), 160'(k % 2));
      if (done_q[k] == 0) n0++;
    end
    check("cont_m0_total", 160'(n0), 160'(3));

    // wrap/skip: pointer moved to 3, then m1 and m2 request
    clear_masters();
    do_reset();
    mv[2] = 1'b1;
    step(); step();
    mv[2] = 1'b0; mv[1] = 1'b1; mv[2] = 1'b1;
    done_q.delete();
    for (int c = 0; c < 20 && done_q.size() < 2; c++) begin
      step();
      for (int i = 0; i < N; i++) if (got[i]) mv[i] = 1'b0;
    end
    check("wrap_n", 160'(done_q.size()), 160'(2));
    check("wrap_first", 160'(done_q.size() > 0 ? done_q[0] : -1), 160'(1));
    check("wrap_second", 160'(done_q.size() > 1 ? done_q[1] : -1), 160'(2));
    mv[0] = 1'b1; mv[3] = 1'b1; s_ready = 1'b0;
    step(); step();
    check("wrap_ptr3", 160'(smp_gid), 160'(3));

    // abort: granted m1 drops valid while the slave answers
    clear_masters();
    do_reset();
    mv[1] = 1'b1;
    step(); step();
    mv[1] = 1'b0; s_ready = 1'b1;
    step();
    check("abort_no_ready", 160'(smp_mresp[RESP_W]), 160'(0));
    check("abort_s_valid", 160'(smp_sreq[REQ_W-1]), 160'(0));
    s_ready = 1'b0; mv[0] = 1'b1; mv[2] = 1'b1; mv[3] = 1'b1;
    step();
    check("abort_idle", 160'(smp_busy), 160'(0));
    step();
    check("abort_ptr", 160'(smp_gid), 160'(2));

`ifdef ARB_TIMEOUT_EN
    // watchdog: silent slave, m1 queued behind m0
    clear_masters();
    do_reset();
    mv[0] = 1'b1; mv[1] = 1'b1; s_ready = 1'b0;
    step();
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      nb++;
      if (smp_mresp[0]) break;
    end
    check("to_cycles", 160'(nb), 160'(TO + 1));
    check("to_rdata", 160'(smp_mresp[RESP_W-1:0]), 160'({32'hDEADBEEF, 1'b1}));
    mv[0] = 1'b0;
    step();
    check("to_sticky", 160'(timeout), 160'(1));
    step();
    check("to_next_m1", 160'(smp_gid), 160'(1));
    s_ready = 1'b1;
    step();
    mv[1] = 1'b0; s_ready = 1'b0;
    step();
    check("to_still_set", 160'(timeout), 160'(1));
`endif

    // random traffic, masters obey hold-until-ready
    clear_masters();
    do_reset();
    got = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (got[i] || !mv[i]) begin
          mv[i] = 1'($urandom_range(0, 1));
          ma[i] = $urandom; mw[i] = $urandom; ms[i] = 4'($urandom);
        end
      end
      s_ready = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
